// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT_RSP = 2'd1,
        PRESENT  = 2'd2,
        FAULT    = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction addresses must be word aligned; any low bit set is a fault.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - 32-bit program counter register with load enable
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_load,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);

    logic [31:0] r_pc;

    // Hold the PC; only advance when the fetch FSM commits a next address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_VAL;
        end else if (i_load) begin
            r_pc <= i_d;
        end
    end

    assign o_q = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch FSM with retire counter
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] Instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        fault,
    output logic [31:0] retired_count
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_instr;
    logic [31:0]  r_retired_count;
    logic [31:0]  w_pc;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_next_pc;
    logic         w_pc_load;
    logic         w_instr_load;
    logic         w_handshake;

    assign w_pc_plus4 = w_pc + 32'd4;
    assign w_next_pc  = PCSrc ? PCTarget : w_pc_plus4;

    pc_reg #(
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_pc_load),
        .i_d     (w_next_pc),
        .o_q     (w_pc)
    );

    // State register; reset abandons any outstanding memory response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode; branch inputs only matter at retire.
    always_comb begin
        w_state_next   = r_state;
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        w_instr_load   = 1'b0;
        w_pc_load      = 1'b0;
        w_handshake    = 1'b0;
        case (r_state)
            FETCH: begin
                imem_req_valid = reset_n;
                if (imem_req_ready) begin
                    w_state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (imem_rsp_valid) begin
                    w_instr_load = 1'b1;
                    w_state_next = PRESENT;
                end
            end
            PRESENT: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    w_handshake = 1'b1;
                    if (PCSrc && is_misaligned(PCTarget)) begin
                        w_state_next = FAULT;
                    end else begin
                        w_pc_load    = 1'b1;
                        w_state_next = FETCH;
                    end
                end
            end
            FAULT: begin
                w_state_next = FAULT;
            end
            default: begin
                w_state_next = FETCH;
            end
        endcase
    end

    // Instruction holding register, written only by a response in WAIT_RSP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instr <= NOP_INSTR;
        end else if (w_instr_load) begin
            r_instr <= imem_rsp_data;
        end
    end

    // Retire counter; a faulting retire is still an accepted instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retired_count <= 32'd0;
        end else if (w_handshake) begin
            r_retired_count <= r_retired_count + 32'd1;
        end
    end

    assign imem_addr     = w_pc;
    assign PC            = w_pc;
    assign PCPlus4       = w_pc_plus4;
    assign Instr         = r_instr;
    assign op            = r_instr[6:0];
    assign funct3        = r_instr[14:12];
    assign funct7b5      = r_instr[30];
    assign fault         = (r_state == FAULT);
    assign retired_count = r_retired_count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table-driven bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] D   = 32'h0050_0093;
    localparam logic [31:0] E   = 32'h4000_5033;
    localparam logic [31:0] F   = 32'h00A0_0113;

    logic        clk;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] Instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        fault;
    logic [31:0] retired_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        ps;
        logic [31:0] pt;
        logic        ir;
        logic        e_req;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_fault;
        logic [31:0] e_rc;
    } vec_t;

    vec_t tbl[$];

    fetch_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .PCSrc          (PCSrc),
        .PCTarget       (PCTarget),
        .instr_ready    (instr_ready),
        .instr_valid    (instr_valid),
        .Instr          (Instr),
        .op             (op),
        .funct3         (funct3),
        .funct7b5       (funct7b5),
        .PC             (PC),
        .PCPlus4        (PCPlus4),
        .fault          (fault),
        .retired_count  (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input logic rr, input logic rv, input logic [31:0] rd,
                               input logic ps, input logic [31:0] pt, input logic ir,
                               input logic e_req, input logic e_iv, input logic [31:0] e_instr,
                               input logic [31:0] e_pc, input logic e_fault, input logic [31:0] e_rc);
        vec_t t;
        t.rr = rr; t.rv = rv; t.rd = rd; t.ps = ps; t.pt = pt; t.ir = ir;
        t.e_req = e_req; t.e_iv = e_iv; t.e_instr = e_instr;
        t.e_pc = e_pc; t.e_fault = e_fault; t.e_rc = e_rc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a vector at the falling edge, check outputs 1ns later, advance one cycle.
    task automatic run_vec(input vec_t t, input string tag);
        logic [31:0] ei;
        imem_req_ready = t.rr;
        imem_rsp_valid = t.rv;
        imem_rsp_data  = t.rd;
        PCSrc          = t.ps;
        PCTarget       = t.pt;
        instr_ready    = t.ir;
        #1;
        ei = t.e_instr;
        chk({tag, ".req_valid"},   {31'd0, imem_req_valid}, {31'd0, t.e_req});
        chk({tag, ".instr_valid"}, {31'd0, instr_valid},    {31'd0, t.e_iv});
        chk({tag, ".addr"},        imem_addr,     t.e_pc);
        chk({tag, ".pc"},          PC,            t.e_pc);
        chk({tag, ".pcplus4"},     PCPlus4,       t.e_pc + 32'd4);
        chk({tag, ".instr"},       Instr,         t.e_instr);
        chk({tag, ".op"},          {25'd0, op},   {25'd0, ei[6:0]});
        chk({tag, ".funct3"},      {29'd0, funct3},   {29'd0, ei[14:12]});
        chk({tag, ".funct7b5"},    {31'd0, funct7b5}, {31'd0, ei[30]});
        chk({tag, ".fault"},       {31'd0, fault},    {31'd0, t.e_fault});
        chk({tag, ".retired"},     retired_count, t.e_rc);
        @(negedge clk);
    endtask

    // Assert reset between edges, check the immediate reset state, release on a falling edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        chk({tag, ".rst_req_valid"},   {31'd0, imem_req_valid}, 32'd0);
        chk({tag, ".rst_instr_valid"}, {31'd0, instr_valid},    32'd0);
        chk({tag, ".rst_fault"},       {31'd0, fault},          32'd0);
        chk({tag, ".rst_pc"},          PC,                      32'h0000_0000);
        chk({tag, ".rst_instr"},       Instr,                   NOP);
        chk({tag, ".rst_retired"},     retired_count,           32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n        = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        PCSrc          = 1'b0;
        PCTarget       = 32'd0;
        instr_ready    = 1'b0;

        // Zero-wait stream, branch, stalled retire, redirect to top of memory and wrap.
        tbl.push_back(v(1,1,D,0,0,1,            1,0,NOP,32'h0,0,0));
        tbl.push_back(v(1,1,D,0,0,1,            0,0,NOP,32'h0,0,0));
        tbl.push_back(v(1,1,D,0,0,1,            0,1,D,32'h0,0,0));
        tbl.push_back(v(1,1,D,0,0,1,            1,0,D,32'h4,0,1));
        tbl.push_back(v(1,1,D,0,0,1,            0,0,D,32'h4,0,1));
        tbl.push_back(v(1,1,D,0,0,1,            0,1,D,32'h4,0,1));
        tbl.push_back(v(1,1,D,0,0,1,            1,0,D,32'h8,0,2));
        tbl.push_back(v(1,1,E,0,0,1,            0,0,D,32'h8,0,2));
        tbl.push_back(v(1,1,E,1,32'h10,1,       0,1,E,32'h8,0,2));
        tbl.push_back(v(1,1,32'hDEADBEEF,1,32'h80,1, 1,0,E,32'h10,0,3));
        tbl.push_back(v(1,1,D,1,32'h80,1,       0,0,E,32'h10,0,3));
        tbl.push_back(v(1,1,32'hBAD00000,1,32'h80,0, 0,1,D,32'h10,0,3));
        tbl.push_back(v(1,1,D,1,32'h40,1,       0,1,D,32'h10,0,3));
        tbl.push_back(v(1,1,D,0,0,1,            1,0,D,32'h40,0,4));
        tbl.push_back(v(1,1,D,0,0,1,            0,0,D,32'h40,0,4));
        tbl.push_back(v(1,1,D,1,32'hFFFFFFFC,1, 0,1,D,32'h40,0,4));
        tbl.push_back(v(1,1,D,0,0,1,            1,0,D,32'hFFFFFFFC,0,5));
        tbl.push_back(v(1,1,E,0,0,1,            0,0,D,32'hFFFFFFFC,0,5));
        tbl.push_back(v(1,1,E,0,0,1,            0,1,E,32'hFFFFFFFC,0,5));
        tbl.push_back(v(1,1,E,0,0,1,            1,0,E,32'h0,0,6));

        do_reset("t0");
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("tbl%0d", i));
        end

        // Memory back-pressure then delayed response; spurious response while presenting.
        do_reset("bp");
        for (int i = 0; i < 4; i++) run_vec(v(0,0,0,0,0,0, 1,0,NOP,0,0,0), $sformatf("bp_stall%0d", i));
        run_vec(v(1,0,0,0,0,0, 1,0,NOP,0,0,0), "bp_accept");
        for (int i = 0; i < 3; i++) run_vec(v(0,0,F,0,0,0, 0,0,NOP,0,0,0), $sformatf("bp_wait%0d", i));
        run_vec(v(0,1,F,0,0,0,                   0,0,NOP,0,0,0), "bp_rsp");
        run_vec(v(0,1,32'h12345678,0,0,0,        0,1,F,0,0,0),   "bp_present");
        run_vec(v(0,0,0,0,0,0,                   0,1,F,0,0,0),   "bp_spurious");
        run_vec(v(0,0,0,0,0,1,                   0,1,F,0,0,0),   "bp_retire");
        run_vec(v(0,0,0,0,0,0,                   1,0,F,32'h4,0,1), "bp_next");

        // Misaligned branch target: sticky fault, no requests, count still advances.
        do_reset("ft");
        run_vec(v(1,1,D,0,0,1,          1,0,NOP,0,0,0), "ft_fetch");
        run_vec(v(1,1,D,0,0,1,          0,0,NOP,0,0,0), "ft_wait");
        run_vec(v(1,1,D,1,32'h42,1,     0,1,D,0,0,0),   "ft_present");
        for (int i = 0; i < 3; i++) run_vec(v(1,1,D,1,32'h80,1, 0,0,D,0,1,1), $sformatf("ft_hold%0d", i));
        do_reset("ft_clear");

        // Reset while a response is outstanding; the late response must be dropped.
        run_vec(v(1,0,0,0,0,0, 1,0,NOP,0,0,0), "lr_fetch");
        run_vec(v(0,0,0,0,0,0, 0,0,NOP,0,0,0), "lr_wait");
        do_reset("lr");
        run_vec(v(0,1,D,0,0,0, 1,0,NOP,0,0,0), "lr_late_rsp");
        run_vec(v(0,0,D,0,0,0, 1,0,NOP,0,0,0), "lr_after");
        run_vec(v(1,0,D,0,0,0, 1,0,NOP,0,0,0), "lr_accept");
        run_vec(v(0,0,D,0,0,0, 0,0,NOP,0,0,0), "lr_wait2");

        // Retire counter wrap from the all-ones value.
        do_reset("wr");
        force dut.r_retired_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired_count;
        run_vec(v(1,1,D,0,0,1, 1,0,NOP,0,0,32'hFFFFFFFF), "wr_fetch");
        run_vec(v(1,1,D,0,0,1, 0,0,NOP,0,0,32'hFFFFFFFF), "wr_wait");
        run_vec(v(1,1,D,0,0,1, 0,1,D,0,0,32'hFFFFFFFF),   "wr_present");
        run_vec(v(1,1,D,0,0,1, 1,0,D,32'h4,0,32'h0),      "wr_wrapped");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, address of first instruction fetched after reset.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 imem_addr  output  32  byte address of request, equals PC.
REQ-007 imem_rsp_valid  input  1  instruction word returned this cycle.
REQ-008 imem_rsp_data  input  32  returned instruction word.
REQ-009 PCSrc  input  1  from controller: take branch/jump target for current instruction.
REQ-010 PCTarget  input  32  branch/jump target from datapath.
REQ-011 instr_ready  input  1  downstream accepts (retires) presented instruction.
REQ-012 instr_valid  output  1  Instr/PC/PCPlus4 valid for consumer.
REQ-013 Instr  output  32  held instruction word.
REQ-014 op, funct3, funct7b5  output  7/3/1  Instr[6:0], Instr[14:12], Instr[30], feeding the controller.
REQ-015 PC, PCPlus4  output  32/32  address of Instr and PC+4.
REQ-016 fault  output  1  sticky misaligned-target flag.
REQ-017 retired_count  output  32  number of instructions accepted downstream.

Function
REQ-018 FSM states SHALL be FETCH, WAIT_RSP, PRESENT, FAULT.
REQ-019 FETCH: imem_req_valid=1, imem_addr=PC; on imem_req_ready go to WAIT_RSP, else hold.
REQ-020 WAIT_RSP: imem_req_valid=0; on imem_rsp_valid capture imem_rsp_data into Instr, go to PRESENT.
REQ-021 imem_rsp_valid outside WAIT_RSP SHALL be ignored (Instr unchanged).
REQ-022 PRESENT: instr_valid=1; Instr, PC, PCPlus4 stable until handshake (instr_valid && instr_ready).
REQ-023 On handshake: next PC = PCSrc ? PCTarget : PC+4; PCSrc/PCTarget sampled only in that cycle.
REQ-024 On handshake with PCSrc=1 and PCTarget[1:0]!=0: PC unchanged, go to FAULT; otherwise go to FETCH.
REQ-025 FAULT: fault=1, instr_valid=0, imem_req_valid=0, held until reset.
REQ-026 PC arithmetic SHALL be 32-bit modulo; PC=32'hFFFF_FFFC sequential next is 32'h0000_0000.
REQ-027 retired_count SHALL increment by 1 per handshake, wrapping 32'hFFFF_FFFF -> 0; faulting handshake also counts.
REQ-028 Minimum throughput one instruction per 3 cycles (FETCH, WAIT_RSP, PRESENT, zero-wait memory).
REQ-029 PCPlus4 SHALL be combinational PC+4; op/funct3/funct7b5 combinational slices of Instr.
REQ-030 instr_ready while not in PRESENT SHALL have no effect.

Reset
REQ-031 reset_n low SHALL immediately force state FETCH, PC=RESET_PC, Instr=32'h0000_0013 (NOP), retired_count=0, fault=0.
REQ-032 During reset: imem_req_valid=0, instr_valid=0; first request issued on first rising edge after deassertion.
REQ-033 Reset asserted mid-WAIT_RSP SHALL discard the outstanding response; a late imem_rsp_valid after reset is ignored per REQ-021.

Structure
REQ-034 Shared package fetch_pkg SHALL hold the state enum, NOP_INSTR constant, and default RESET_PC.
REQ-035 PC register with async active-low reset SHALL be a sub-module pc_reg (32-bit, load enable, reset value parameter).
REQ-036 All remaining logic in fetch_unit, target 120-400 RTL lines.

Verification
REQ-037 Reset release, zero-wait memory returning 32'h00500093, instr_ready=1 -> imem_addr 0, 4, 8 on successive FETCH cycles, Instr=32'h00500093, op=7'h13, retired_count increments every 3 cycles.
REQ-038 PC=0x10 in PRESENT, PCSrc=1, PCTarget=0x40 at handshake -> next imem_addr=0x40; PCSrc=1 with instr_ready=0 -> no redirect, PC stays 0x10.
REQ-039 imem_req_ready low 4 cycles, then rsp delayed 3 cycles -> imem_addr held, instr_valid rises exactly one cycle after rsp_valid; spurious rsp_valid in PRESENT leaves Instr unchanged.
REQ-040 Handshake with PCSrc=1, PCTarget=0x42 -> fault=1 next cycle, no further requests, PC unchanged, retired_count +1; reset_n low clears fault and PC=RESET_PC.
REQ-041 PC=0xFFFF_FFFC, PCSrc=0 handshake -> next imem_addr=0x0000_0000; retired_count preloaded via 2^32-1 handshakes (or forced) wraps to 0.
REQ-042 reset_n pulsed low in WAIT_RSP, response arrives after release -> response ignored, Instr=NOP, new request at RESET_PC.
